mag_accum_seq: RTL

// - Parametrised successor to the valid-pipelined square-root accumulator.
// - Computes the running recurrence f <= floor(sqrt(f + a*a)) for every accepted sample.
// - Square root is iterative: one root bit per cycle.
// - Full ready/valid handshake on both sides, plus a per-sample clear that restarts accumulation.
// - Sits between the sample source and the downstream consumer of magnitude results.

---
 rtl/mag_accum_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mag_accum_seq.sv
// mag_accum_seq
//   Running magnitude accumulator: for every accepted sample computes
//   f <= floor(sqrt(f + a*a)) with an iterative restoring square root that
//   produces one root bit per cycle. Ready/valid handshake on both sides.
//
//   Parameters
//     DATA_W  width of unsigned input sample a
//     ACC_W   radicand width (even, >= 2*DATA_W+2); root width R = ACC_W/2
//     CNT_W   sample-counter width (only with MAG_SAMPLE_COUNT_EN)
//
//   Ports
//     clk, reset   clock; synchronous active-high reset
//     a            input sample
//     valid_in     sample (and clear) valid this cycle
//     ready_in     block idle and able to accept a sample
//     clear        restart accumulation: previous f treated as 0
//     f            current root, zero-extended to ACC_W, registered
//     valid_out    f holds a new result awaiting handshake
//     ready_out    downstream accepts the result
//     sample_cnt   saturating accepted-sample count (MAG_SAMPLE_COUNT_EN only)
//
//   Optional feature macro: MAG_SAMPLE_COUNT_EN
module mag_accum_seq #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              clear,
  output logic [ACC_W-1:0]  f,
  output logic              valid_out,
  input  logic              ready_out
`ifdef MAG_SAMPLE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  sample_cnt
`endif
);

  localparam int R  = ACC_W / 2;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, SQRT, DONE} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] rad;
  logic [R+1:0]     rem;
  logic [R-1:0]     root;
  logic [IW-1:0]    iter;

  logic [R+1:0]     rem_shift, trial, rem_step;
  logic [R-1:0]     root_step;
  logic             take;
  logic             last_iter;
  logic [ACC_W-1:0] a_ext, f_prev, rad_load;

  // One restoring-sqrt step. The remainder never exceeds 2*root, so its low
  // R bits are enough before shifting in the next radicand bit pair.
  always_comb begin
    rem_shift = {rem[R-1:0], rad[ACC_W-1 -: 2]};
    trial     = {root, 2'b01};
    take      = (rem_shift >= trial);
    rem_step  = take ? (rem_shift - trial) : rem_shift;
    root_step = {root[R-2:0], take};
    last_iter = (iter == '0);
    a_ext     = ACC_W'(a);
    f_prev    = clear ? '0 : ACC_W'(f[R-1:0]);
    rad_load  = (a_ext * a_ext) + f_prev;
  end

  always_comb begin
    state_next = state;
    ready_in   = 1'b0;
    case (state)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) state_next = SQRT;
      end
      SQRT: if (last_iter) state_next = DONE;
      DONE: if (ready_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f         <= '0;
      valid_out <= 1'b0;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            rad  <= rad_load;
            rem  <= '0;
            root <= '0;
            iter <= IW'(R - 1);
          end
        end
        SQRT: begin
          rad  <= rad << 2;
          rem  <= rem_step;
          root <= root_step;
          if (last_iter) begin
            f         <= ACC_W'(root_step);
            valid_out <= 1'b1;
          end else begin
            iter <= iter - 1'b1;
          end
        end
        DONE: if (ready_out) valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MAG_SAMPLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (state == IDLE && valid_in) begin
      if (clear)                sample_cnt <= CNT_W'(1);
      else if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
    end
  end
`endif

endmodule
